lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the core's memory stage and the data memory port (addr/rdata/wdata/ren/wen).
- Drives the data-memory port that the testbench memory interface monitors from the memory side.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned transactions with byte enables.
- Waits for a memory acknowledge, then returns sign- or zero-extended load data, or an error for misalignment or timeout.

Parameters:
- ADDR_WIDTH, 32, byte-address width. Bits [1:0] select the byte lane.
- TIMEOUT_CYCLES, 15, maximum cycles a request is held without i_mem_ack before aborting. Range 1..255.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  block can accept a request.
- i_req_we  in  1  1=store, 0=load.
- i_req_funct3  in  3  RV32I load/store funct3.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- o_rsp_err  out  1  valid with o_rsp_valid: misaligned, illegal funct3, or timeout.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- o_mem_ren  out  1  memory read request.
- o_mem_wen  out  1  memory write request.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ack  in  1  memory completes the current request this cycle.
- i_mem_rdata  in  32  read word, valid when i_mem_ack=1.

Behaviour:
- **Reset values.** While i_rst=1, all registered outputs are 0 and the state is IDLE. o_req_ready = (state==IDLE) & ~i_rst.
- **States:**
  - IDLE: o_req_ready=1. A request is accepted when i_req_valid & o_req_ready. It is checked in the same cycle.
    - A request is illegal if funct3 is 3, 6 or 7, or if misaligned (H with addr[0]=1, W with addr[1:0]≠0). Illegal requests go to RESP with err=1 and no memory access.
    - A legal request is latched and goes to REQ.
  - REQ: o_mem_ren/o_mem_wen, addr, be and wdata are registered and held stable until ack. A wait counter clears on entry.
    - On i_mem_ack: capture and format rdata, go to RESP with err=0.
    - Else, when counter==TIMEOUT_CYCLES-1: deassert ren/wen, go to RESP with err=1.
    - If ack and timeout expiry coincide, the ack wins.
  - RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. Strobes drop on RESP entry.
- **Latency.** Accept at cycle 0, memory strobe visible at cycle 1. Ack at cycle k gives o_rsp_valid at k+1. Zero-wait memory (ack at cycle 1) gives rsp at cycle 2. An illegal request gives rsp at cycle 1.
- **Byte enables:**
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111; lane selection happens in the formatter.
- **Load format.** The selected byte or half of i_mem_rdata is extended: sign-extended for LB/LH, zero-extended for LBU/LHU. LW passes through.
- **Spurious inputs.** i_mem_ack in IDLE or RESP is ignored. i_req_valid outside IDLE is not accepted and has no effect.
- **Reset mid-operation.** i_rst in REQ or RESP aborts immediately: strobes drop next edge and no response is issued.

Decomposition:
- lsu_pkg holds:
  - state enum (IDLE, REQ, RESP);
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5 (stores use 0/1/2);
  - function is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, lsu_lane_align, handles store replication and byte-enable generation plus load extraction and extension. The FSM, counter and registers stay in lsu_mem_master.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack at cycle 1 -> o_mem_addr=0x100, be=1111, wen=1 at cycle 1; rsp_valid at cycle 2, err=0.
- LB addr=0x203, mem word 0x80FF1234, ack after 3 waits -> o_mem_addr=0x200; rdata=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH addr=0x12, wdata=0x0000ABCD -> be=1100, o_mem_wdata=0xABCDABCD. LH addr=0x11 -> rsp at cycle 1, err=1, no ren/wen ever asserted.
- LW with no ack, TIMEOUT_CYCLES=15 -> ren high for exactly 15 cycles, then rsp_valid with err=1 and rdata=0.
- Ack on the final timeout cycle -> err=0 with data captured. Spurious ack in IDLE -> no rsp.
- i_rst asserted in REQ after 2 wait cycles -> ren=0 next cycle, no rsp_valid. A new request is accepted the first cycle after reset deasserts.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared constants and helpers for the load/store memory master.
package lsu_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // RV32I load funct3 codes; stores reuse 0/1/2 for SB/SH/SW
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic r;
    r = 1'b0;
    if (funct3[1:0] == 2'd1 && lane[0]) r = 1'b1;
    if (funct3[1:0] == 2'd2 && lane != 2'd0) r = 1'b1;
    return r;
  endfunction

  // Loads accept 0,1,2,4,5; stores only 0,1,2 (there is no unsigned store).
  function automatic logic is_bad_funct3(input logic we, input logic [2:0] funct3);
    logic r;
    r = 1'b0;
    if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) r = 1'b1;
    if (we && funct3[2]) r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory port signals of the load/store master.
interface lsu_mem_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [2:0]            i_req_funct3;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [31:0]           i_req_wdata;
  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_ren;
  logic                  o_mem_wen;
  logic [3:0]            o_mem_be;
  logic [31:0]           o_mem_wdata;
  logic                  i_mem_ack;
  logic [31:0]           i_mem_rdata;

  // View from the load/store master
  modport master (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_be, o_mem_wdata
  );

  // View from the core/memory environment
  modport slave (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_be, o_mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master_lane_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic is_unsigned);
    logic signed [7:0] s;
    s = b;
    return is_unsigned ? {24'd0, b} : 32'(s);
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic is_unsigned);
    logic signed [15:0] s;
    s = h;
    return is_unsigned ? {16'd0, h} : 32'(s);
  endfunction

  logic [31:0] shifted;

  // Stores: replicate the datum across all lanes and enable only the target bytes
  always_comb begin
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    if (st_we) begin
      case (st_funct3[1:0])
        2'd0: begin
          st_be        = 4'b0001 << st_lane;
          st_wdata_rep = {4{st_wdata[7:0]}};
        end
        2'd1: begin
          st_be        = st_lane[1] ? 4'b1100 : 4'b0011;
          st_wdata_rep = {2{st_wdata[15:0]}};
        end
        default: begin
          st_be        = 4'b1111;
          st_wdata_rep = st_wdata;
        end
      endcase
    end
  end

  // Loads: move the addressed lane to bit 0, then extend per funct3[2]
  always_comb begin
    shifted = ld_word >> {ld_lane, 3'b000};
    case (ld_funct3[1:0])
      2'd0:    ld_data = ext8(shifted[7:0], ld_funct3[2]);
      2'd1:    ld_data = ext16(shifted[15:0], ld_funct3[2]);
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one core request, runs one memory transaction, returns a response.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic              i_clk,
  input logic              i_rst,
  lsu_mem_master_if.master bus
);

  logic [1:0]            state;
  logic [7:0]            wait_cnt;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ren;
  logic                  mem_wen;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic                  accept;
  logic                  illegal;
  logic [3:0]            be_next;
  logic [31:0]           wdata_next;
  logic [31:0]           load_fmt;

  lsu_lane_align u_align (
    .st_we        (bus.i_req_we),
    .st_funct3    (bus.i_req_funct3),
    .st_lane      (bus.i_req_addr[1:0]),
    .st_wdata     (bus.i_req_wdata),
    .st_be        (be_next),
    .st_wdata_rep (wdata_next),
    .ld_funct3    (funct3_q),
    .ld_lane      (lane_q),
    .ld_word      (bus.i_mem_rdata),
    .ld_data      (load_fmt)
  );

  assign bus.o_req_ready = (state == ST_IDLE) & ~i_rst;
  assign accept          = bus.i_req_valid & bus.o_req_ready;
  assign illegal         = is_bad_funct3(bus.i_req_we, bus.i_req_funct3) |
                           is_misaligned(bus.i_req_funct3, bus.i_req_addr[1:0]);

  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_ren   = mem_ren;
  assign bus.o_mem_wen   = mem_wen;
  assign bus.o_mem_be    = mem_be;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_rsp_err   = rsp_err;

  // FSM: accept/check in IDLE, hold the memory strobe in REQ, pulse the response in RESP
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      lane_q    <= '0;
      mem_addr  <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (illegal) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ST_REQ;
              wait_cnt  <= '0;
              we_q      <= bus.i_req_we;
              funct3_q  <= bus.i_req_funct3;
              lane_q    <= bus.i_req_addr[1:0];
              mem_addr  <= {bus.i_req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_ren   <= ~bus.i_req_we;
              mem_wen   <= bus.i_req_we;
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end
        ST_REQ: begin
          // An ack on the last allowed cycle still completes normally
          if (bus.i_mem_ack) begin
            state     <= ST_RESP;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? 32'd0 : load_fmt;
          end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state     <= ST_RESP;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with hand-computed expectations.
module tb_lsu_mem_master;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   ren_cycles;

  lsu_mem_master_if #(.ADDR_WIDTH(32)) bus ();

  lsu_mem_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge; returns 1 ns into cycle 1
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wdata;
    bus.i_req_valid  = 1'b1;
    tick();
    bus.i_req_valid  = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'd0;
    bus.i_req_addr   = '0;
    bus.i_req_wdata  = '0;
    bus.i_mem_ack    = 1'b0;
    bus.i_mem_rdata  = '0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
    chk("rst_ren",   32'(bus.o_mem_ren),   32'd0);
    chk("rst_wen",   32'(bus.o_mem_wen),   32'd0);
    chk("rst_rsp",   32'(bus.o_rsp_valid), 32'd0);
    chk("rst_addr",  bus.o_mem_addr,       32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.o_req_ready), 32'd1);

    // SW 0x100, zero-wait ack
    issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_addr",  bus.o_mem_addr,       32'h100);
    chk("sw_be",    32'(bus.o_mem_be),    32'hF);
    chk("sw_wen",   32'(bus.o_mem_wen),   32'd1);
    chk("sw_ren",   32'(bus.o_mem_ren),   32'd0);
    chk("sw_wdata", bus.o_mem_wdata,      32'hDEADBEEF);
    chk("sw_ready", 32'(bus.o_req_ready), 32'd0);
    chk("sw_rsp1",  32'(bus.o_rsp_valid), 32'd0);
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    chk("sw_rsp",   32'(bus.o_rsp_valid), 32'd1);
    chk("sw_err",   32'(bus.o_rsp_err),   32'd0);
    chk("sw_rdata", bus.o_rsp_rdata,      32'd0);
    chk("sw_wen_d", 32'(bus.o_mem_wen),   32'd0);
    tick();
    chk("sw_rsp_end", 32'(bus.o_rsp_valid), 32'd0);
    chk("sw_idle",    32'(bus.o_req_ready), 32'd1);

    // LB 0x203 with 3 wait cycles, then LBU
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, (u == 0) ? 3'd0 : 3'd4, 32'h203, 32'h0);
      chk("lb_addr", bus.o_mem_addr,     32'h200);
      chk("lb_ren",  32'(bus.o_mem_ren), 32'd1);
      chk("lb_be",   32'(bus.o_mem_be),  32'hF);
      tick();
      tick();
      tick();
      chk("lb_wait_rsp", 32'(bus.o_rsp_valid), 32'd0);
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 32'h80FF1234;
      tick();
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = 32'h0;
      chk("lb_rsp",   32'(bus.o_rsp_valid), 32'd1);
      chk("lb_err",   32'(bus.o_rsp_err),   32'd0);
      chk("lb_rdata", bus.o_rsp_rdata, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
      tick();
    end

    // LW passthrough
    issue(1'b0, 3'd2, 32'h44, 32'h0);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h89ABCDEF;
    tick();
    bus.i_mem_ack   = 1'b0;
    chk("lw_rdata", bus.o_rsp_rdata, 32'h89ABCDEF);
    tick();

    // SB 0x101
    issue(1'b1, 3'd0, 32'h101, 32'h12345655);
    chk("sb_be",    32'(bus.o_mem_be), 32'h2);
    chk("sb_wdata", bus.o_mem_wdata,   32'h55555555);
    chk("sb_addr",  bus.o_mem_addr,    32'h100);
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    tick();

    // SH 0x12
    issue(1'b1, 3'd1, 32'h12, 32'h0000ABCD);
    chk("sh_be",    32'(bus.o_mem_be),  32'hC);
    chk("sh_wdata", bus.o_mem_wdata,    32'hABCDABCD);
    chk("sh_addr",  bus.o_mem_addr,     32'h10);
    chk("sh_wen",   32'(bus.o_mem_wen), 32'd1);
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    chk("sh_rsp", 32'(bus.o_rsp_valid), 32'd1);
    tick();

    // LH 0x11 misaligned: response at cycle 1, no memory strobe
    issue(1'b0, 3'd1, 32'h11, 32'h0);
    chk("lhmis_rsp", 32'(bus.o_rsp_valid), 32'd1);
    chk("lhmis_err", 32'(bus.o_rsp_err),   32'd1);
    chk("lhmis_ren", 32'(bus.o_mem_ren),   32'd0);
    chk("lhmis_wen", 32'(bus.o_mem_wen),   32'd0);
    tick();
    chk("lhmis_rsp_end", 32'(bus.o_rsp_valid), 32'd0);
    chk("lhmis_ren2",    32'(bus.o_mem_ren),   32'd0);

    // Illegal funct3 = 3
    issue(1'b0, 3'd3, 32'h20, 32'h0);
    chk("f3bad_err", 32'(bus.o_rsp_err), 32'd1);
    chk("f3bad_ren", 32'(bus.o_mem_ren), 32'd0);
    tick();

    // LW timeout; a request offered mid-wait must not disturb the transaction
    issue(1'b0, 3'd2, 32'h40, 32'h0);
    ren_cycles = 0;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_addr  = 32'h300;
    if (bus.o_mem_ren) ren_cycles++;
    tick();
    bus.i_req_valid = 1'b0;
    chk("to_addr_hold", bus.o_mem_addr,     32'h40);
    chk("to_wen_hold",  32'(bus.o_mem_wen), 32'd0);
    for (int i = 0; i < 40 && bus.o_mem_ren; i++) begin
      ren_cycles++;
      tick();
    end
    chk("to_ren_cycles", 32'(ren_cycles),     32'd15);
    chk("to_rsp",        32'(bus.o_rsp_valid), 32'd1);
    chk("to_err",        32'(bus.o_rsp_err),   32'd1);
    chk("to_rdata",      bus.o_rsp_rdata,      32'd0);
    tick();
    chk("to_idle", 32'(bus.o_req_ready), 32'd1);

    // Ack on the final timeout cycle wins
    issue(1'b0, 3'd1, 32'h2, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("late_ren", 32'(bus.o_mem_ren), 32'd1);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h80017FFF;
    tick();
    bus.i_mem_ack   = 1'b0;
    chk("late_rsp",   32'(bus.o_rsp_valid), 32'd1);
    chk("late_err",   32'(bus.o_rsp_err),   32'd0);
    chk("late_rdata", bus.o_rsp_rdata,      32'hFFFF8001);
    tick();

    // Spurious ack while idle
    bus.i_mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_rsp", 32'(bus.o_rsp_valid), 32'd0);
      chk("spur_ren", 32'(bus.o_mem_ren),   32'd0);
    end
    bus.i_mem_ack = 1'b0;

    // Reset during REQ after two wait cycles
    issue(1'b0, 3'd2, 32'h80, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_ren",   32'(bus.o_mem_ren),   32'd0);
    chk("mrst_rsp",   32'(bus.o_rsp_valid), 32'd0);
    chk("mrst_ready", 32'(bus.o_req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(bus.o_req_ready), 32'd1);
    issue(1'b0, 3'd4, 32'h1, 32'h0);
    chk("post_ren",  32'(bus.o_mem_ren), 32'd1);
    chk("post_addr", bus.o_mem_addr,     32'h0);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0000AB00;
    tick();
    bus.i_mem_ack   = 1'b0;
    chk("post_rsp",   32'(bus.o_rsp_valid), 32'd1);
    chk("post_rdata", bus.o_rsp_rdata,      32'h000000AB);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
